// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM state encoding and default width.
package div_unit_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left by one, subtract the divisor on trial.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] dv,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             borrow;

  // The shifted partial remainder can reach WIDTH+1 bits; one more bit holds the borrow.
  assign shifted = {rem_in, quo_in[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, dv};
  assign borrow  = trial[WIDTH+1];

  assign quo_out = {quo_in[WIDTH-2:0], ~borrow};
  assign rem_out = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU: magnitudes in, WIDTH steps, sign fix-up out.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dv_r;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  logic             dd_neg;
  logic             dv_neg;

  // Two's-complement negate on request; -2^(WIDTH-1) maps onto itself, read as unsigned.
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                   input logic            neg);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  assign dd_neg = is_signed & dividend[WIDTH-1];
  assign dv_neg = is_signed & divisor[WIDTH-1];

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in  (rem_r),
    .quo_in  (quo_r),
    .dv      (dv_r),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  // Control: state, step counter and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= DIV_IDLE;
      count     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          done <= 1'b0;
          if (start) begin
            count <= CNT_W'(WIDTH);
            busy  <= 1'b1;
            state <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          count <= count - 1'b1;
          if (count == CNT_W'(1)) begin
            state <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          quotient  <= apply_sign(quo_r, sign_q);
          remainder <= apply_sign(rem_r, sign_r);
          done      <= 1'b1;
          busy      <= 1'b0;
          state     <= DIV_IDLE;
        end
        default: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath: operand capture on accept, one restoring step per RUN cycle.
  always_ff @(posedge clk) begin
    if (state == DIV_IDLE && start) begin
      quo_r  <= apply_sign(dividend, dd_neg);
      dv_r   <= apply_sign(divisor, dv_neg);
      rem_r  <= '0;
      sign_q <= dd_neg ^ dv_neg;
      sign_r <= dd_neg;
    end else if (state == DIV_RUN) begin
      rem_r <= rem_nx;
      quo_r <= quo_nx;
    end
  end

endmodule
